// File: rtl/bus_arbiter_rr.sv
// N-master bus arbiter: round-robin or fixed priority, bounded ownership
// window with preemption, per-master lock, registered one-hot grant.
//
// Ports:
//   clk, rst      clock; asynchronous active-high reset
//   req[N]        level requests, bit i = master i
//   lock[N]       bit i high = master i's ownership must not be preempted
//   bus_busy      blocks new grants while high (ignored during ownership)
//   grant[N]      registered one-hot grant
//   grant_valid   OR of grant
//   grant_id      encoded owner index, 0 when idle
//   preempt       one-cycle pulse when ownership ended by hold timeout
//   rr_ptr        current highest-priority index
module bus_arbiter_rr #(
    parameter int N_MASTERS = 4,
    parameter int RR_MODE   = 1,
    parameter int MAX_HOLD  = 16,
    parameter int ID_W      = $clog2(N_MASTERS)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [N_MASTERS-1:0] req,
    input  logic [N_MASTERS-1:0] lock,
    input  logic                 bus_busy,
    output logic [N_MASTERS-1:0] grant,
    output logic                 grant_valid,
    output logic [ID_W-1:0]      grant_id,
    output logic                 preempt,
    output logic [ID_W-1:0]      rr_ptr
);

    localparam int HC_W = (MAX_HOLD < 1) ? 1 : $clog2(MAX_HOLD + 1);
    localparam logic [HC_W-1:0] HOLD_MAX = HC_W'(MAX_HOLD);
    localparam logic [ID_W:0]   N_W      = (ID_W + 1)'(N_MASTERS);
    localparam logic [ID_W-1:0] LAST_ID  = ID_W'(N_MASTERS - 1);

    typedef enum logic {
        IDLE,
        OWN
    } state_t;

    state_t              state;
    logic [HC_W-1:0]     hold_cnt;

    logic [ID_W-1:0]     base;
    logic [2*N_MASTERS-1:0] req_dbl;
    logic [N_MASTERS-1:0]   req_rot;
    logic [ID_W-1:0]     win_off;
    logic [ID_W:0]       win_sum;
    logic [ID_W-1:0]     win_id;
    logic                win_found;

    logic                own_req;
    logic                own_lock;
    logic                other_req;
    logic                timeout;
    logic                do_release;
    logic                do_preempt;
    logic [ID_W-1:0]     ptr_next;

    assign base    = (RR_MODE != 0) ? rr_ptr : '0;
    // Rotate requests so the highest-priority master lands at bit 0.
    assign req_dbl = {req, req} >> base;
    assign req_rot = req_dbl[N_MASTERS-1:0];

    always_comb begin
        win_off   = '0;
        win_found = 1'b0;
        for (int k = 0; k < N_MASTERS; k++) begin
            if (!win_found && req_rot[k]) begin
                win_found = 1'b1;
                win_off   = ID_W'(k);
            end
        end
    end

    // Undo the rotation: winner = (base + offset) mod N.
    always_comb begin
        win_sum = {1'b0, base} + {1'b0, win_off};
        if (win_sum >= N_W) begin
            win_sum = win_sum - N_W;
        end
        win_id = win_sum[ID_W-1:0];
    end

    // grant is one-hot on the owner, so masking picks the owner's bits.
    assign own_req    = |(req & grant);
    assign own_lock   = |(lock & grant);
    assign other_req  = |(req & ~grant);
    assign timeout    = (MAX_HOLD != 0) && (hold_cnt == HOLD_MAX);
    assign do_preempt = own_req && timeout && !own_lock && other_req;
    assign do_release = !own_req || do_preempt;
    assign ptr_next   = (grant_id == LAST_ID) ? '0 : grant_id + 1'b1;

    assign grant_valid = |grant;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            grant    <= '0;
            grant_id <= '0;
            preempt  <= 1'b0;
            rr_ptr   <= '0;
            hold_cnt <= '0;
        end else begin
            preempt <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (!bus_busy && win_found) begin
                        state    <= OWN;
                        grant    <= N_MASTERS'(1) << win_id;
                        grant_id <= win_id;
                        hold_cnt <= HC_W'(1);
                    end
                end
                OWN: begin
                    if (do_release) begin
                        state    <= IDLE;
                        grant    <= '0;
                        grant_id <= '0;
                        preempt  <= do_preempt;
                        rr_ptr   <= (RR_MODE != 0) ? ptr_next : '0;
                    end else if (MAX_HOLD != 0 && hold_cnt != HOLD_MAX) begin
                        hold_cnt <= hold_cnt + 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_bus_arbiter_rr.sv
// Bench for bus_arbiter_rr: directed scenarios plus random traffic,
// three configurations checked every cycle against a behavioural model.
module tb_bus_arbiter_rr;

    logic       clk;
    logic       rst;
    logic [3:0] req4, lock4;
    logic       busy;
    logic [6:0] req7, lock7;
    logic       busy7;

    logic [3:0] g_rr, g_fp;
    logic       gv_rr, gv_fp, pre_rr, pre_fp;
    logic [1:0] gid_rr, gid_fp, ptr_rr, ptr_fp;
    logic [6:0] g_n7;
    logic       gv_n7, pre_n7;
    logic [2:0] gid_n7, ptr_n7;

    int  n_tests = 0;
    int  n_fail  = 0;
    bit  chk_en  = 0;

    bus_arbiter_rr #(.N_MASTERS(4), .RR_MODE(1), .MAX_HOLD(4)) u_rr (
        .clk(clk), .rst(rst), .req(req4), .lock(lock4), .bus_busy(busy),
        .grant(g_rr), .grant_valid(gv_rr), .grant_id(gid_rr),
        .preempt(pre_rr), .rr_ptr(ptr_rr)
    );

    bus_arbiter_rr #(.N_MASTERS(4), .RR_MODE(0), .MAX_HOLD(4)) u_fp (
        .clk(clk), .rst(rst), .req(req4), .lock(lock4), .bus_busy(busy),
        .grant(g_fp), .grant_valid(gv_fp), .grant_id(gid_fp),
        .preempt(pre_fp), .rr_ptr(ptr_fp)
    );

    bus_arbiter_rr #(.N_MASTERS(7), .RR_MODE(1), .MAX_HOLD(0)) u_n7 (
        .clk(clk), .rst(rst), .req(req7), .lock(lock7), .bus_busy(busy7),
        .grant(g_n7), .grant_valid(gv_n7), .grant_id(gid_n7),
        .preempt(pre_n7), .rr_ptr(ptr_n7)
    );

    initial clk = 0;
    always #5 clk = ~clk;

    // Behavioural model: who owns the bus, for how long, and the pointer.
    typedef struct {
        bit own;
        int owner;
        int cnt;
        int ptr;
        bit pre;
    } ms_t;

    ms_t m_rr, m_fp, m_n7;

    function automatic ms_t ms_reset();
        ms_t t;
        t.own = 0; t.owner = 0; t.cnt = 0; t.ptr = 0; t.pre = 0;
        return t;
    endfunction

    function automatic ms_t step(ms_t s, int n, bit rr, int mh,
                                 logic [15:0] rq, logic [15:0] lk, bit bsy);
        ms_t t;
        bit done;
        int cand;
        int others;
        t = s;
        t.pre = 0;
        if (!s.own) begin
            done = 0;
            if (!bsy) begin
                for (int k = 0; k < n; k++) begin
                    cand = rr ? (s.ptr + k) % n : k;
                    if (!done && rq[cand]) begin
                        done = 1;
                        t.own = 1;
                        t.owner = cand;
                        t.cnt = 1;
                    end
                end
            end
        end else begin
            others = 0;
            for (int k = 0; k < n; k++)
                if (k != s.owner && rq[k]) others++;
            if (!rq[s.owner]) begin
                t.own = 0;
                t.ptr = rr ? (s.owner + 1) % n : 0;
            end else if (mh != 0 && s.cnt >= mh && !lk[s.owner] && others > 0) begin
                t.own = 0;
                t.pre = 1;
                t.ptr = rr ? (s.owner + 1) % n : 0;
            end else if (s.cnt < mh) begin
                t.cnt = s.cnt + 1;
            end
        end
        return t;
    endfunction

    function automatic logic [25:0] exp_vec(ms_t s);
        logic [15:0] g;
        logic [3:0]  id;
        g  = s.own ? (16'(1) << s.owner) : 16'h0;
        id = s.own ? 4'(s.owner) : 4'h0;
        return {g, id, s.pre, 4'(s.ptr), s.own};
    endfunction

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_rr <= ms_reset();
            m_fp <= ms_reset();
            m_n7 <= ms_reset();
        end else begin
            m_rr <= step(m_rr, 4, 1, 4, 16'(req4), 16'(lock4), busy);
            m_fp <= step(m_fp, 4, 0, 4, 16'(req4), 16'(lock4), busy);
            m_n7 <= step(m_n7, 7, 1, 0, 16'(req7), 16'(lock7), busy7);
        end
    end

    task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (!rst && chk_en) begin
            chk("model_rr", 32'({16'(g_rr), 4'(gid_rr), pre_rr, 4'(ptr_rr), gv_rr}),
                32'(exp_vec(m_rr)));
            chk("model_fp", 32'({16'(g_fp), 4'(gid_fp), pre_fp, 4'(ptr_fp), gv_fp}),
                32'(exp_vec(m_fp)));
            chk("model_n7", 32'({16'(g_n7), 4'(gid_n7), pre_n7, 4'(ptr_n7), gv_n7}),
                32'(exp_vec(m_n7)));
        end
    end

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    int ord [5] = '{0, 1, 2, 3, 0};
    int z;
    int n;
    int o;

    initial begin
        rst = 1; req4 = 0; lock4 = 0; busy = 0;
        req7 = 0; lock7 = 0; busy7 = 0;
        repeat (2) tick();
        rst = 0;
        chk_en = 1;
        tick();
        chk("reset_grant", 32'(g_rr), 0);
        chk("reset_ptr", 32'(ptr_rr), 0);

        // Async reset while master 2 owns the bus.
        req4 = 4'b0100;
        tick();
        chk("t1_grant2", 32'(g_rr), 32'h4);
        #2 rst = 1;
        #1;
        chk("t1_async_rr", 32'(g_rr), 0);
        chk("t1_async_fp", 32'(g_fp), 0);
        tick();
        req4 = 0;
        rst = 0;
        tick();
        chk("t1_ptr", 32'(ptr_rr), 0);
        chk("t1_preempt", 32'(pre_rr), 0);

        // Round-robin fairness.
        req4 = 4'b1111;
        for (int i = 0; i < 5; i++) begin
            z = 0;
            tick();
            while (g_rr == 0 && z < 10) begin
                z++;
                tick();
            end
            chk("t2_latency", 32'(z), 0);
            chk("t2_order", 32'(gid_rr), 32'(ord[i]));
            o = int'(gid_rr);
            tick();
            chk("t2_hold2", 32'(g_rr), 32'(1 << ord[i]));
            req4[o] = 1'b0;
            tick();
            chk("t2_gap", 32'(g_rr), 0);
            chk("t2_ptr", 32'(ptr_rr), 32'((ord[i] + 1) % 4));
            req4[o] = 1'b1;
        end
        req4 = 0;
        repeat (2) tick();

        // Fixed priority.
        req4 = 4'b1010;
        tick();
        chk("t3_win1", 32'(gid_fp), 1);
        tick();
        req4[1] = 1'b0;
        tick();
        chk("t3_drop", 32'(g_fp), 0);
        tick();
        chk("t3_m3", 32'({gv_fp, gid_fp}), 32'h7);
        req4[1] = 1'b1;
        n = 0;
        while (!(gv_fp && gid_fp == 2'd1) && n < 12) begin
            n++;
            tick();
        end
        chk("t3_rewin1", 32'({gv_fp, gid_fp}), 32'h5);
        chk("t3_ptr", 32'(ptr_fp), 0);
        req4 = 0;
        repeat (2) tick();

        // Preemption after MAX_HOLD=4 cycles.
        req4 = 4'b0100;
        tick();
        chk("t4_g2", 32'(g_rr), 32'h4);
        tick();
        req4[0] = 1'b1;
        n = 2;
        tick();
        while (g_rr == 4'b0100 && n < 20) begin
            n++;
            tick();
        end
        chk("t4_hold_len", 32'(n), 4);
        chk("t4_preempt", 32'({pre_rr, g_rr}), 32'h10);
        tick();
        chk("t4_next", 32'({pre_rr, g_rr}), 32'h01);
        req4 = 0;
        repeat (2) tick();

        // Same with lock: no preemption.
        lock4 = 4'b0100;
        req4  = 4'b0100;
        tick();
        tick();
        req4[0] = 1'b1;
        for (int i = 0; i < 8; i++) begin
            tick();
            chk("t4_lock_keep", 32'({pre_rr, g_rr}), 32'h04);
        end
        req4[2] = 1'b0;
        tick();
        chk("t4_lock_drop", 32'({pre_rr, g_rr}), 32'h00);
        tick();
        chk("t4_lock_next", 32'(g_rr), 32'h1);
        req4 = 0;
        lock4 = 0;
        repeat (2) tick();

        // bus_busy gating.
        busy = 1;
        req4 = 4'b0100;
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("t5_busy_idle", 32'(g_rr), 0);
        end
        busy = 0;
        tick();
        chk("t5_grant", 32'(g_rr), 32'h4);
        busy = 1;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("t5_own_busy", 32'(g_rr), 32'h4);
        end
        busy = 0;
        req4 = 0;
        repeat (2) tick();

        // Seven masters with pointer wrap-around.
        req7 = 7'b0010000;
        tick();
        chk("t6_g4", 32'(gid_n7), 4);
        req7 = 0;
        tick();
        chk("t6_ptr5", 32'(ptr_n7), 5);
        req7 = 7'b0000011;
        tick();
        chk("t6_wrap", 32'({gv_n7, gid_n7}), 32'h8);
        req7 = 0;
        tick();
        chk("t6_ptr1", 32'(ptr_n7), 1);
        chk("pin_model_ptr", 32'(m_n7.ptr), 1);

        // Random traffic.
        for (int c = 0; c < 3000; c++) begin
            req4  = req4 ^ (4'($urandom) & 4'($urandom));
            req7  = req7 ^ (7'($urandom) & 7'($urandom) & 7'($urandom));
            if ($urandom_range(0, 15) == 0) lock4 = 4'($urandom);
            if ($urandom_range(0, 15) == 0) lock7 = 7'($urandom);
            busy  = ($urandom_range(0, 3) == 0);
            busy7 = ($urandom_range(0, 3) == 0);
            if (c == 1500) begin
                #2 rst = 1;
                #1;
                chk("rand_async", 32'({g_n7, g_rr, g_fp}), 0);
                tick();
                rst = 0;
            end
            tick();
        end

        chk_en = 0;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/bus_arbiter_rr.md
Name: bus_arbiter_rr

Overview:
Parametrised N-master bus arbiter. It generalises the team's fixed 4-master rotating-priority arbiter to any master count and adds the following:
- selectable round-robin or fixed-priority mode
- a bounded ownership window with preemption
- per-master lock
- an explicit owner index output

It sits between the bus masters and the shared bus mux, and drives the mux select from grant_id.

Parameters:
N_MASTERS, 4, number of requesting masters (2..16)
RR_MODE, 1, 1 = round-robin rotating priority, 0 = fixed priority (lowest index wins)
MAX_HOLD, 16, max consecutive grant cycles before preemption is allowed; 0 = unlimited
ID_W, $clog2(N_MASTERS), width of index outputs (derived, do not override)

Ports:
clk  in  1  clock
rst  in  1  reset, asynchronous, active-high
req  in  N_MASTERS  request, bit i = master i; level, held while bus is wanted
lock  in  N_MASTERS  bit i high = master i's ownership must not be preempted
bus_busy  in  1  bus still completing a transfer; no new grant issued while high
grant  out  N_MASTERS  one-hot grant, registered
grant_valid  out  1  OR of grant
grant_id  out  ID_W  index of current owner; 0 when grant_valid=0
preempt  out  1  one-cycle pulse: ownership ended by MAX_HOLD timeout
rr_ptr  out  ID_W  current highest-priority index (round-robin pointer)

Behaviour:
- Reset (async): grant=0, grant_valid=0, grant_id=0, preempt=0, rr_ptr=0, hold_cnt=0, state=IDLE. Asserting rst mid-grant clears grant immediately, without waiting for a clock edge.
- State machine: IDLE, OWN.
- IDLE:
  - If bus_busy=0 and req!=0, the winner is registered at that edge: grant[w]=1, grant_id=w, hold_cnt=1, next state OWN.
  - Latency is one clock from sampled req to visible grant.
  - bus_busy=1 or req=0 keeps the block in IDLE with grant=0.
- Winner selection:
  - RR_MODE=1: first set req bit scanning rr_ptr, rr_ptr+1, ... wrapping modulo N_MASTERS.
  - RR_MODE=0: lowest set index; rr_ptr is held at 0.
- OWN, owner o. Exits are evaluated in this order:
  1. req[o]=0: grant drops at next edge, state IDLE, rr_ptr=(o+1) mod N (RR mode).
  2. MAX_HOLD!=0, hold_cnt==MAX_HOLD, lock[o]=0, and any other req bit set: grant drops at next edge, preempt=1 for that one cycle, state IDLE, rr_ptr=(o+1) mod N.
  3. Otherwise: keep grant; hold_cnt increments, saturating at MAX_HOLD.
- Timeout with no competing request: ownership continues and hold_cnt stays saturated. Preemption fires on the first cycle a competitor appears.
- lock[o]=1 suppresses preemption only; it does not keep the grant after req[o] drops.
- bus_busy is ignored in OWN; it gates only new grants.
- Handoff gap: at least one IDLE cycle (grant=0) between any two owners. The same master re-requesting is arbitrated normally against the others.
- Invariants:
  - grant is always one-hot or zero.
  - grant_id always equals the encoded grant.
  - no combinational path exists from req to grant.
- hold_cnt width: $clog2(MAX_HOLD+1), minimum 1 bit.

Test Plan:
1. Reset: rst=1 while grant[2]=1 -> grant=0 in the same cycle, before any clk edge; rr_ptr=0, preempt=0 after release.
2. Round-robin fairness (N=4, RR_MODE=1): req=4'b1111 held, each owner drops req for 1 cycle after 2 grant cycles.
   - Grant order is 0,1,2,3,0.
   - Each grant is preceded by exactly one grant=0 cycle.
   - rr_ptr reads 1,2,3,0 after the respective releases.
3. Fixed priority (RR_MODE=0): req=4'b1010, master 1 releases and re-requests.
   - Master 1 wins every arbitration.
   - Master 3 is granted only while req[1]=0; rr_ptr stays 0.
4. Preemption (MAX_HOLD=4): master 2 granted, req[0] rises during master 2's 2nd grant cycle.
   - Grant to 2 lasts exactly 4 cycles.
   - preempt=1 in the cycle grant drops.
   - grant[0]=1 one cycle later.
   - Repeat with lock[2]=1: no preempt, master 2 keeps grant until req[2]=0.
5. bus_busy gating: req=4'b0100 with bus_busy=1 for 5 cycles, then 0.
   - grant=0 throughout the busy period.
   - grant[2]=1 on the cycle after the first edge that samples bus_busy=0.
   - Raising bus_busy during OWN leaves the grant untouched.
6. Parametrisation: N_MASTERS=7, RR_MODE=1, rr_ptr=5, req=7'b0000011 -> grant_id=0, and after release rr_ptr=1 (wrap-around).
